// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the datapath (master) and the multiply/divide engine (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, din1, din2,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, din1, din2,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO engine: shift-add multiply and restoring divide, one bit per clock.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the unconsumed multiplier bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             res_neg, rem_neg, dz;
    logic [WIDTH-1:0] acc, low, opb;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             accept, last_iter, early_out, is_mul;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    // acc is the running upper half; l holds product low bits above the unconsumed multiplier bits
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] l,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0]   sum;
        logic [2*WIDTH:0] wide;
        sum  = {1'b0, a} + (l[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        wide = {sum, l};
        return wide[2*WIDTH:1];
    endfunction

    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] rs, trial;
        rs    = {r, q[WIDTH-1]};
        trial = rs - {1'b0, d};
        if (rs >= {1'b0, d})
            return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        else
            return {rs[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    assign is_mul    = ~op_q[1];
    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W:0] shamt;
    assign shamt     = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
    assign early_out = is_mul && ((low & ({WIDTH{1'b1}} >> cnt)) == '0);
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (last_iter || early_out) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = bus.start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and architected result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz      <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= '0;
                op_q    <= bus.op;
                res_neg <= ~bus.op[0] & (bus.din1[WIDTH-1] ^ bus.din2[WIDTH-1]);
                rem_neg <= ~bus.op[0] & bus.din1[WIDTH-1];
                dz      <= bus.op[1] & (bus.din2 == '0);
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX) begin
                if (is_mul) begin
                    {hi_q, lo_q} <= res_neg ? neg_2w({acc, low}) : {acc, low};
                end else begin
                    // divisor 0: remainder path rebuilds the original dividend bits
                    hi_q <= rem_neg ? neg_w(acc) : acc;
                    lo_q <= dz ? {WIDTH{1'b1}} : (res_neg ? neg_w(low) : low);
                end
            end
        end
    end

    // Iteration datapath: magnitudes in, one bit per clock
    always_ff @(posedge clk) begin
        if (accept) begin
            acc <= '0;
            low <= bus.op[1] ? abs_w(bus.din1, ~bus.op[0]) : abs_w(bus.din2, ~bus.op[0]);
            opb <= bus.op[1] ? abs_w(bus.din2, ~bus.op[0]) : abs_w(bus.din1, ~bus.op[0]);
        end else if (state == CALC) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (early_out)
                {acc, low} <= {acc, low} >> shamt;
            else
`endif
            if (is_mul)
                {acc, low} <= mul_step(acc, low, opb);
            else
                {acc, low} <= div_step(acc, low, opb);
        end
    end

    assign bus.busy     = (state == CALC) || (state == FIX);
    assign bus.done     = (state == DONE);
    assign bus.div_zero = (state == DONE) && dz;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, divide by zero, reset abort.
module tb_muldiv_unit;
  localparam int WIDTH = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 4;
`else
  localparam int EO_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(WIDTH)) bus ();
  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Issues one request; latency is the cycle (1 = cycle after the accepting edge) where done is seen.
  task automatic do_op(input bit now, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt, output logic busy_at_done,
                       output logic dzs, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    if (!now) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.din1 = a; bus.din2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.din1 = $urandom; bus.din2 = $urandom;
    lat = 0; busy_cnt = 0; busy_at_done = 1'bx; dzs = 1'bx;
    mid_hi = bus.hi; mid_lo = bus.lo;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 10) begin mid_hi = bus.hi; mid_lo = bus.lo; end
      if (bus.done) begin
        lat = c; busy_at_done = bus.busy; dzs = bus.div_zero;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.din1 = '0; bus.din2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int lat, bc; logic bd, dzs; logic [31:0] mh, ml;
    do_op(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, bd, dzs, mh, ml);
    checks++; if (lat !== 34) begin errors++; $display("FAIL multu_max_lat got %0d want 34", lat); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo got %h want 00000001", bus.lo); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_max_busy_cycles got %0d want 33", bc); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL multu_max_busy_at_done got %b want 0", bd); end
    checks++; if (dzs !== 1'b0) begin errors++; $display("FAIL multu_max_dz got %b want 0", dzs); end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.din1 = 32'd7; bus.din2 = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstmid_done_pulses got %0d want 0", dcnt); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo_after got %h want 0", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic bd, dzs; logic [31:0] mh, ml;
    do_op(1'b0, 2'b00, 32'hFFFFFFFD, 32'd5, lat, bc, bd, dzs, mh, ml);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_lat got %0d want 34", lat); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", bus.lo); end
    do_op(1'b1, 2'b10, 32'hFFFFFFF9, 32'd2, lat, bc, bd, dzs, mh, ml);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_div_lat got %0d want 34", lat); end
    checks++; if (mh !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_hold_hi got %h want ffffffff", mh); end
    checks++; if (ml !== 32'hFFFFFFF1) begin errors++; $display("FAIL b2b_hold_lo got %h want fffffff1", ml); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_div_special();
    int lat, bc; logic bd, dzs; logic [31:0] mh, ml;
    do_op(1'b0, 2'b11, 32'd100, 32'd0, lat, bc, bd, dzs, mh, ml);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divz_lat got %0d want 34", lat); end
    checks++; if (bus.hi !== 32'd100) begin errors++; $display("FAIL divz_hi got %h want 00000064", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", bus.lo); end
    checks++; if (dzs !== 1'b1) begin errors++; $display("FAIL divz_flag got %b want 1", dzs); end
    @(negedge clk);
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL divz_pulse_width got %b want 0", bus.div_zero); end
    do_op(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc, bd, dzs, mh, ml);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 0", bus.hi); end
    checks++; if (dzs !== 1'b0) begin errors++; $display("FAIL ovf_dz got %b want 0", dzs); end
  endtask

  task automatic test_busy_ignore();
    int dcnt = 0;
    int lat = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.din1 = 32'd3; bus.din2 = 32'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin dcnt++; if (lat == 0) lat = c; end
      if (c == 5) begin bus.start = 1'b1; bus.din1 = 32'd5; bus.din2 = 32'd6; end
      if (c == 6) bus.start = 1'b0;
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d want 1", dcnt); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_lat got %0d want 34", lat); end
    checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL ignore_lo got %h want 0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_early_out();
    int lat, bc; logic bd, dzs; logic [31:0] mh, ml;
    do_op(1'b0, 2'b01, 32'd6, 32'd1, lat, bc, bd, dzs, mh, ml);
    checks++; if (lat !== EO_LAT) begin errors++; $display("FAIL early_lat got %0d want %0d", lat, EO_LAT); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL early_lo got %h want 00000006", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL early_hi got %h want 0", bus.hi); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_reset_mid();
    test_back_to_back();
    test_div_special();
    test_busy_ignore();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
